// File: rtl/next_pc_sequencer.sv
// Six-step instruction sequencer that collects redirect requests during steps 0..4
// and registers the resolved next-PC on the edge leaving step 4.
module next_pc_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        halt,
  input  logic        br_req,
  input  logic        br_taken,
  input  logic [15:0] br_off,
  input  logic        j_req,
  input  logic [25:0] j_tgt,
  input  logic        jr_req,
  input  logic [31:0] jr_tgt,
  output logic [31:0] pc_next,
  output logic [2:0]  step,
  output logic        pc_load,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  typedef enum logic [2:0] {
    STEP0 = 3'd0,
    STEP1 = 3'd1,
    STEP2 = 3'd2,
    STEP3 = 3'd3,
    STEP4 = 3'd4,
    STEP5 = 3'd5
  } step_t;

  step_t state, state_nxt;

  logic        accept, clear, commit;
  logic        jr_v, j_v, br_v;
  logic [29:0] jr_lat;
  logic [25:0] j_lat;
  logic [15:0] br_lat;
  logic        br_hit;
  logic        jr_eff, j_eff, br_eff;
  logic [29:0] jr_addr;
  logic [25:0] j_addr;
  logic [15:0] br_sel;
  logic [31:0] br_target;
  logic [31:0] target;

  // NOTE: sequential state uses <= so every flop samples pre-edge values; blocking
  // assignments here would make results depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= STEP0;
    else       state <= state_nxt;
  end

  // NOTE: defaulting every always_comb output first means no path leaves it
  // unassigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (!halt) begin
      unique case (state)
        STEP0:   state_nxt = STEP1;
        STEP1:   state_nxt = STEP2;
        STEP2:   state_nxt = STEP3;
        STEP3:   state_nxt = STEP4;
        STEP4:   state_nxt = STEP5;
        default: state_nxt = STEP0;
      endcase
    end
  end

  always_comb begin
    step    = state;
    pc_load = (state == STEP5);
  end

  assign accept = !halt && (state != STEP5);
  assign clear  = !halt && (state == STEP5);
  assign commit = !halt && (state == STEP4);
  assign br_hit = br_req && br_taken;

  // NOTE: these are a handful of plain registers, so all of them are reset;
  // only large storage arrays would be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      jr_v   <= 1'b0;
      j_v    <= 1'b0;
      br_v   <= 1'b0;
      jr_lat <= '0;
      j_lat  <= '0;
      br_lat <= '0;
    end else if (clear) begin
      jr_v <= 1'b0;
      j_v  <= 1'b0;
      br_v <= 1'b0;
    end else if (accept) begin
      if (jr_req) begin
        jr_v   <= 1'b1;
        jr_lat <= jr_tgt[31:2];
      end
      if (j_req) begin
        j_v   <= 1'b1;
        j_lat <= j_tgt;
      end
      if (br_hit) begin
        br_v   <= 1'b1;
        br_lat <= br_off;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                     misalign <= 1'b0;
    else if (accept && jr_req && |jr_tgt[1:0])     misalign <= 1'b1;
  end

  // Same-edge requests take part in the step-4 resolution and overwrite older data.
  assign jr_eff  = jr_v || jr_req;
  assign j_eff   = j_v || j_req;
  assign br_eff  = br_v || br_hit;
  assign jr_addr = jr_req ? jr_tgt[31:2] : jr_lat;
  assign j_addr  = j_req  ? j_tgt        : j_lat;
  assign br_sel  = br_hit ? br_off       : br_lat;

  assign pc_plus4  = pc_cur + 32'd4;
  assign br_target = pc_plus4 + {{14{br_sel[15]}}, br_sel, 2'b00};

  always_comb begin
    target = pc_plus4;
    if (jr_eff)      target = {jr_addr, 2'b00};
    else if (j_eff)  target = {pc_plus4[31:28], j_addr, 2'b00};
    else if (br_eff) target = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset)       pc_next <= '0;
    else if (commit) pc_next <= target;
  end

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Bench for next_pc_sequencer: directed scenarios plus random traffic, all checked
// against a request-list model that resolves the next PC once per instruction.
module tb_next_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, halt, br_req, br_taken, j_req, jr_req;
  logic [31:0] pc_cur, jr_tgt;
  logic [15:0] br_off;
  logic [25:0] j_tgt;
  logic [31:0] pc_next, pc_plus4;
  logic [2:0]  step;
  logic        pc_load, misalign;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          kind;  // 0 taken branch, 1 jump, 2 register jump
    logic [31:0] data;
  } req_t;

  req_t        q[$];
  int          m_step = 0;
  logic [31:0] m_pc_next = '0;
  logic        m_mis = 1'b0;

  next_pc_sequencer dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .halt(halt),
    .br_req(br_req), .br_taken(br_taken), .br_off(br_off),
    .j_req(j_req), .j_tgt(j_tgt), .jr_req(jr_req), .jr_tgt(jr_tgt),
    .pc_next(pc_next), .step(step), .pc_load(pc_load),
    .pc_plus4(pc_plus4), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Highest-priority kind wins; within a kind the most recent request wins.
  function automatic logic [31:0] resolve();
    logic [31:0] p4;
    p4 = pc_cur + 32'd4;
    for (int k = 2; k >= 0; k--) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].kind == k) begin
          if (k == 2) return q[i].data & 32'hFFFF_FFFC;
          if (k == 1) return (p4 & 32'hF000_0000) | (q[i].data << 2);
          return p4 + 32'($signed(q[i].data[15:0]) * 4);
        end
      end
    end
    return p4;
  endfunction

  task automatic tick();
    if (reset) begin
      m_step = 0; m_pc_next = '0; m_mis = 1'b0; q.delete();
    end else if (!halt) begin
      if (m_step <= 4) begin
        if (jr_req) begin
          q.push_back('{2, jr_tgt});
          if (jr_tgt[1:0] != 2'b00) m_mis = 1'b1;
        end
        if (j_req) q.push_back('{1, {6'b0, j_tgt}});
        if (br_req && br_taken) q.push_back('{0, {16'b0, br_off}});
      end
      if (m_step == 4) m_pc_next = resolve();
      if (m_step == 5) q.delete();
      m_step = (m_step + 1) % 6;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; halt = 0; br_req = 0; br_taken = 0; j_req = 0; jr_req = 0;
    br_off = '0; j_tgt = '0; jr_tgt = '0;
  endtask

  task automatic run_to(input int s);
    for (int i = 0; i < 12 && m_step != s; i++) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_cur = 32'h0040_0000;
    reset = 1;
    tick(); tick();
    reset = 0;
    n_tests++; if (step !== 3'd0) begin n_fail++; $display("FAIL reset_step got=%0d exp=0", step); end
    n_tests++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL reset_pc_next got=%h exp=0", pc_next); end
    n_tests++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL reset_pc_load got=%b exp=0", pc_load); end
    n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
  endtask

  task automatic test_sequential();
    int loads = 0;
    pc_cur = 32'h0040_0000;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pc_load === 1'b1) loads++;
      n_tests++; if (step !== 3'(m_step)) begin n_fail++; $display("FAIL seq_step got=%0d exp=%0d", step, m_step); end
      n_tests++; if (pc_load !== (m_step == 5)) begin n_fail++; $display("FAIL seq_pc_load got=%b exp=%b", pc_load, m_step == 5); end
      if (m_step == 5) begin
        n_tests++; if (pc_next !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc_next got=%h exp=00400004", pc_next); end
      end
    end
    n_tests++; if (loads != 2) begin n_fail++; $display("FAIL seq_load_count got=%0d exp=2", loads); end
    n_tests++; if (pc_plus4 !== 32'h0040_0004) begin n_fail++; $display("FAIL seq_pc_plus4 got=%h exp=00400004", pc_plus4); end
  endtask

  task automatic test_branch();
    run_to(0);
    pc_cur = 32'h0040_0010;
    run_to(2);
    br_req = 1; br_taken = 1; br_off = 16'hFFFE;
    tick();
    idle_inputs();
    run_to(5);
    n_tests++; if (pc_next !== 32'h0040_000C) begin n_fail++; $display("FAIL br_taken got=%h exp=0040000c", pc_next); end
    run_to(2);
    br_req = 1; br_taken = 0; br_off = 16'hFFFE;
    tick();
    idle_inputs();
    run_to(5);
    n_tests++; if (pc_next !== 32'h0040_0014) begin n_fail++; $display("FAIL br_not_taken got=%h exp=00400014", pc_next); end
  endtask

  task automatic test_priority();
    pc_cur = 32'h0040_0000;
    run_to(3);
    j_req = 1; j_tgt = 26'h010_0000; jr_req = 1; jr_tgt = 32'h0040_0100;
    tick();
    idle_inputs();
    run_to(5);
    n_tests++; if (pc_next !== 32'h0040_0100) begin n_fail++; $display("FAIL prio_jr_over_j got=%h exp=00400100", pc_next); end
    run_to(3);
    j_req = 1; j_tgt = 26'h010_0000;
    tick();
    idle_inputs();
    run_to(5);
    n_tests++; if (pc_next !== 32'h0040_0000) begin n_fail++; $display("FAIL prio_j_alone got=%h exp=00400000", pc_next); end
  endtask

  task automatic test_misalign_wrap();
    pc_cur = 32'h0040_0000;
    run_to(1);
    jr_req = 1; jr_tgt = 32'h0040_0103;
    tick();
    idle_inputs();
    run_to(5);
    n_tests++; if (pc_next !== 32'h0040_0100) begin n_fail++; $display("FAIL mis_pc_next got=%h exp=00400100", pc_next); end
    n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag got=%b exp=1", misalign); end
    pc_cur = 32'hFFFF_FFFC;
    #1;
    n_tests++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4 got=%h exp=0", pc_plus4); end
    run_to(0);
    run_to(5);
    n_tests++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_next got=%h exp=0", pc_next); end
    n_tests++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_sticky got=%b exp=1", misalign); end
  endtask

  task automatic test_halt_late_reset();
    int waited = 0;
    pc_cur = 32'h0040_0010;
    run_to(2);
    halt = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      waited++;
      n_tests++; if (step !== 3'd2) begin n_fail++; $display("FAIL halt_step got=%0d exp=2", step); end
    end
    halt = 0;
    for (int i = 0; i < 10 && pc_load !== 1'b1; i++) begin
      tick();
      waited++;
    end
    n_tests++; if (waited != 6) begin n_fail++; $display("FAIL halt_load_delay got=%0d exp=6", waited); end
    br_req = 1; br_taken = 1; br_off = 16'h0010;
    tick();
    idle_inputs();
    run_to(5);
    n_tests++; if (pc_next !== 32'h0040_0014) begin n_fail++; $display("FAIL late_br_ignored got=%h exp=00400014", pc_next); end
    run_to(4);
    reset = 1; halt = 1; jr_req = 1; jr_tgt = 32'h1234_5679;
    tick();
    idle_inputs();
    n_tests++; if (step !== 3'd0) begin n_fail++; $display("FAIL mid_reset_step got=%0d exp=0", step); end
    n_tests++; if (pc_next !== 32'h0) begin n_fail++; $display("FAIL mid_reset_pc_next got=%h exp=0", pc_next); end
    n_tests++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mid_reset_misalign got=%b exp=0", misalign); end
    tick();
    n_tests++; if (step !== 3'd1) begin n_fail++; $display("FAIL resume_step got=%0d exp=1", step); end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(63) == 0);
      halt     = ($urandom_range(7) == 0);
      br_req   = ($urandom_range(3) == 0);
      br_taken = $urandom_range(1) == 1;
      br_off   = 16'($urandom);
      j_req    = ($urandom_range(5) == 0);
      j_tgt    = 26'($urandom);
      jr_req   = ($urandom_range(7) == 0);
      jr_tgt   = $urandom;
      if ($urandom_range(3) == 0) pc_cur = $urandom;
      tick();
      n_tests++;
      if (step !== 3'(m_step) || pc_load !== (m_step == 5) || pc_next !== m_pc_next ||
          misalign !== m_mis || pc_plus4 !== pc_cur + 32'd4) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand_cycle%0d got step=%0d load=%b next=%h mis=%b p4=%h exp step=%0d next=%h mis=%b",
                   i, step, pc_load, pc_next, misalign, pc_plus4, m_step, m_pc_next, m_mis);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_priority();
    test_misalign_wrap();
    test_halt_late_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
